// File: rtl/sd_send.sv
// SD-bus command transmitter: latches a 38-bit command body, computes its CRC7
// serially, then shifts the 48-bit command token out MSB first on the CMD line.

module sd_crc7 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [39:0] data,
    output logic [6:0]  crc,
    output logic        last,
    output logic        ready
);

    logic [5:0] index;
    logic       busy;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic din);
        logic fb;
        fb = din ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'b0001001 : 7'b0000000);
    endfunction

    // The start edge consumes bit 39 from a zero seed, so the 40 bits occupy 40 edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc   <= 7'd0;
            index <= 6'd39;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (start) begin
            crc   <= crc7_step(7'd0, data[39]);
            index <= 6'd38;
            busy  <= 1'b1;
            ready <= 1'b0;
        end else if (busy) begin
            crc <= crc7_step(crc, data[index]);
            if (index == 6'd0) begin
                busy  <= 1'b0;
                ready <= 1'b1;
                index <= 6'd39;
            end else begin
                index <= index - 6'd1;
            end
        end
    end

    assign last = busy && (index == 6'd0);

endmodule

module sd_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] token,
    output logic        sending,
    output logic        sd_cmd,
    output logic        done
);

    logic [5:0] index;
    logic       busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index   <= 6'd0;
            busy    <= 1'b0;
            sending <= 1'b0;
            sd_cmd  <= 1'b1;
        end else if (load) begin
            index   <= 6'd47;
            busy    <= 1'b1;
            sending <= 1'b0;
            sd_cmd  <= 1'b1;
        end else if (busy) begin
            sending <= 1'b1;
            sd_cmd  <= token[index];
            if (index == 6'd0)
                busy <= 1'b0;
            else
                index <= index - 6'd1;
        end else begin
            sending <= 1'b0;
            sd_cmd  <= 1'b1;
        end
    end

    // High for the one cycle after the final bit has been driven.
    assign done = sending && !busy;

endmodule

module sd_send (
    input  logic        ex_clk,
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [37:0] cmd_content,
    output logic        sending,
    output logic        sd_cmd,
    output logic [3:0]  sd_dat
);

    typedef enum logic [2:0] {IDLE, CRC, LOAD, SEND, DONE} state_t;

    state_t      PS, PS_nxt;
    logic        crc_load, crc_load_nxt;
    logic        body_en, tx_load;
    logic [37:0] cmd_body;
    logic [6:0]  cmd_crc;
    logic        crc_ready, crc_last;
    logic [47:0] cmd_token;
    logic        tx_done;
    logic        unused_ex_clk;

    assign unused_ex_clk = ex_clk;
    assign sd_dat        = 4'hF;

    always_ff @(posedge sd_clk or posedge reset) begin
        if (reset) begin
            PS        <= IDLE;
            crc_load  <= 1'b0;
            cmd_token <= 48'd0;
        end else begin
            PS       <= PS_nxt;
            crc_load <= crc_load_nxt;
            if (tx_load)
                cmd_token <= {1'b0, 1'b1, cmd_body, cmd_crc, 1'b1};
        end
    end

    always_ff @(posedge sd_clk) begin
        if (body_en)
            cmd_body <= cmd_content;
    end

    always_comb begin
        PS_nxt       = PS;
        crc_load_nxt = 1'b0;
        body_en      = 1'b0;
        tx_load      = 1'b0;
        case (PS)
            IDLE: if (send_en) begin
                body_en      = 1'b1;
                crc_load_nxt = 1'b1;
                PS_nxt       = CRC;
            end
            CRC:  if (crc_last) PS_nxt = LOAD;
            LOAD: begin
                tx_load = 1'b1;
                PS_nxt  = SEND;
            end
            SEND: if (tx_done) PS_nxt = DONE;
            DONE: if (!send_en) PS_nxt = IDLE;
            default: PS_nxt = IDLE;
        endcase
    end

    sd_crc7 crc_gen (
        .clk   (sd_clk),
        .reset (reset),
        .start (crc_load),
        .data  ({2'b01, cmd_body}),
        .crc   (cmd_crc),
        .last  (crc_last),
        .ready (crc_ready)
    );

    sd_tx transmitter (
        .clk     (sd_clk),
        .reset   (reset),
        .load    (tx_load),
        .token   (cmd_token),
        .sending (sending),
        .sd_cmd  (sd_cmd),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_sd_send.sv
// Bench for sd_send: fixed SD commands plus random bodies checked against a
// polynomial-division CRC7 model; also covers mid-frame reset and held send_en.
`timescale 1ns/1ps

module tb_sd_send;

    logic        ex_clk, sd_clk, reset, send_en;
    logic [37:0] cmd_content;
    logic        sending, sd_cmd;
    logic [3:0]  sd_dat;

    int n_tests = 0;
    int n_fail  = 0;

    sd_send dut (
        .ex_clk      (ex_clk),
        .sd_clk      (sd_clk),
        .reset       (reset),
        .send_en     (send_en),
        .cmd_content (cmd_content),
        .sending     (sending),
        .sd_cmd      (sd_cmd),
        .sd_dat      (sd_dat)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;
    assign ex_clk = sd_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] token_ref(input logic [37:0] body);
        return {2'b01, body, crc7_ref({2'b01, body}), 1'b1};
    endfunction

    task automatic run_frame(input string tag, input logic [37:0] content, input int hold,
                             input int window, input logic [47:0] exp_tok);
        logic [47:0] got;
        int nbits, first, frames;
        logic prev;
        @(negedge sd_clk);
        cmd_content = content;
        send_en     = 1'b1;
        got = '0; nbits = 0; first = -1; frames = 0; prev = 1'b0;
        for (int c = 1; c <= window; c++) begin
            @(negedge sd_clk);
            if (c == hold) send_en = 1'b0;
            if (c == 3) cmd_content = {6'($urandom), 32'($urandom)};
            if (sending) begin
                if (!prev) begin
                    frames++;
                    if (first < 0) first = c;
                end
                if (nbits < 48) got = {got[46:0], sd_cmd};
                nbits++;
            end
            prev = sending;
        end
        send_en = 1'b0;
        check({tag, " token"}, got, exp_tok);
        check({tag, " latency"}, first - 1, 42);
        check({tag, " nbits"}, nbits, 48);
        check({tag, " frames"}, frames, 1);
        check({tag, " cmd_idle"}, sd_cmd, 1'b1);
        check({tag, " dat"}, sd_dat, 4'hF);
        repeat (2) @(negedge sd_clk);
        check({tag, " ps_idle"}, 64'(dut.PS), 64'd0);
    endtask

    initial begin
        logic [37:0] body;
        int nb;
        reset = 1'b0; send_en = 1'b0; cmd_content = '0;
        #1 reset = 1'b1;
        #0.01 reset = 1'b0;
        #1;
        check("rst sending", sending, 1'b0);
        check("rst sd_cmd", sd_cmd, 1'b1);
        check("rst sd_dat", sd_dat, 4'hF);
        check("rst ps", 64'(dut.PS), 64'd0);

        check("ref cmd0", token_ref(38'd0), 48'h40_0000_0000_95);
        run_frame("cmd0", 38'd0, 2, 100, 48'h40_0000_0000_95);
        run_frame("cmd17", {6'd17, 32'd0}, 2, 100, 48'h51_0000_0000_55);
        run_frame("cmd8", {6'd8, 32'h000001AA}, 1, 100, 48'h48_0000_01AA_87);

        // Reset in the middle of a frame.
        @(negedge sd_clk);
        cmd_content = {6'd17, 32'h12345678};
        send_en = 1'b1;
        nb = 0;
        for (int c = 0; c < 200 && nb < 20; c++) begin
            @(negedge sd_clk);
            if (c == 1) send_en = 1'b0;
            if (sending) nb++;
        end
        check("midrst reached", nb, 20);
        reset = 1'b1;
        #1;
        check("midrst sending", sending, 1'b0);
        check("midrst sd_cmd", sd_cmd, 1'b1);
        check("midrst ps", 64'(dut.PS), 64'd0);
        #1 reset = 1'b0;
        run_frame("after_rst", {6'd17, 32'h12345678}, 2, 100, token_ref({6'd17, 32'h12345678}));

        // Held send_en gives exactly one frame; a fresh request gives another.
        run_frame("held", {6'd55, 32'hDEADBEEF}, 200, 260, token_ref({6'd55, 32'hDEADBEEF}));
        run_frame("second", {6'd55, 32'hDEADBEEF}, 2, 100, token_ref({6'd55, 32'hDEADBEEF}));

        for (int k = 0; k < 6; k++) begin
            body = {6'($urandom), 32'($urandom)};
            run_frame($sformatf("rnd%0d", k), body, 1 + int'($urandom_range(0, 4)), 100,
                      token_ref(body));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_send.md
Name: sd_send

Overview:
- SD-bus command transmitter. It takes a 38-bit command body (6-bit command index plus 32-bit argument) and computes the CRC7.
- It then shifts the complete 48-bit command token out serially, MSB first, on the SD CMD line.
- Sits between the host-controller command FSM and the SD card pins. The DAT lines are held idle.

Parameters:
- None. Frame length 48, body 38 and CRC width 7 are fixed.

Ports:
- ex_clk  input  1  Legacy port kept for interface compatibility. Unused; always driven identically to sd_clk.
- sd_clk  input  1  The single clock. All logic runs on its rising edge.
- reset  input  1  Asynchronous, active-high reset.
- send_en  input  1  Start request, level-sampled in IDLE.
- cmd_content  input  38  {cmd_index[5:0], argument[31:0]}.
- sending  output  1  High exactly while token bits are on sd_cmd.
- sd_cmd  output  1  Serial CMD line. Idles at 1.
- sd_dat  output  4  Constant 4'b1111 (idle).

Behaviour:
- Clocking: one clock domain (sd_clk) only. ex_clk is not connected to any logic.
- Reset values (asynchronous, while reset=1):
  - PS=IDLE, sending=0, sd_cmd=1, sd_dat=4'hF
  - crc_load=0, crc_ready=0, cmd_crc=0, cmd_token=0
  - transmitter and crc_gen index counters reset.
  - Reset mid-operation aborts immediately; no partial frame resumes.
- Token format: cmd_token[47:0] = {1'b0 start, 1'b1 host bit, cmd_content[37:0], cmd_crc[6:0], 1'b1 end}.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - Computed serially over the 40 bits {0,1,cmd_content}, MSB first.
  - Per bit: fb = din ^ crc[6]; crc = {crc[5:0],1'b0} ^ (fb ? 7'b0001001 : 0).
- State machine, register PS: IDLE, CRC, LOAD, SEND, DONE.
  - IDLE:
    - Edge E0 with send_en=1: latch cmd_content, pulse crc_load for one cycle, go to CRC.
    - send_en=0: stay.
  - CRC:
    - Edges E1..E40: one bit per edge.
    - crc_gen.index counts 39 down to 0.
    - After the last bit, crc_ready=1; go to LOAD.
  - LOAD (edge E41): cmd_token assembled; transmitter.index=47; go to SEND.
  - SEND:
    - From edge E42, sending=1 and sd_cmd=cmd_token[transmitter.index].
    - Index decrements each edge.
    - After 48 bits (edge E90), sending=0, sd_cmd=1; go to DONE.
  - DONE: stay until send_en=0, then IDLE. One request yields exactly one frame.
  - send_en changes outside IDLE are ignored. cmd_content is only sampled at E0.
- Output timing:
  - sending and sd_cmd are registered on the same rising edge.
  - A sampler at rising edge k (seeing pre-update values) sees sending=1 for exactly 48 consecutive edges.
  - On the i-th such edge (i=0..47) it sees sd_cmd = cmd_token[47-i].
- Debug names kept for hierarchical probing:
  - PS, crc_load, cmd_crc[6:0], crc_ready, cmd_token[47:0]
  - sub-instance crc_gen containing index
  - sub-instance transmitter containing index
- Latency: 42 cycles from the send_en sample edge to the first bit. Frame length 48 cycles. Back-to-back frames need send_en low for at least one cycle.

Test Plan:
- Reset pulse 10 ps -> sending=0, sd_cmd=1, sd_dat=4'hF, PS=IDLE.
- CMD0: cmd_content=0, send_en high 2 cycles.
  - Required serial stream: 0x40_0000_0000_95, i.e. 01 000000 followed by 32 zeros, CRC 1001010, end 1.
  - Exactly 48 bits with sending high; sd_cmd=1 afterwards.
- CMD17: cmd_content = 6'd17 followed by 32 zeros.
  - Required stream: 0x51_0000_0000_55 (CRC 0101010).
- CMD8: cmd_content = {6'd8, 32'h000001AA} -> stream 0x48_0000_01AA_87 (CRC 1000011).
- Reset asserted during SEND at bit 20 -> sending=0 and sd_cmd=1 immediately.
  - A new send_en afterwards produces a complete, correct frame.
- send_en held high 200 cycles -> only one frame sent. Lowering then raising send_en -> a second frame.
